// File: rtl/group_sel_sequencer_pkg.sv
// group_sel_pkg: shared widths, FSM state, step direction and default slot population
package group_sel_pkg;
  localparam int SEL_W = 4;
  localparam int NSLOT = 1 << SEL_W;
  localparam logic [NSLOT-1:0] DEFAULT_SLOT_MASK = 16'hFEFF;
  typedef enum logic {IDLE, SEARCH} state_t;
  typedef enum logic {DIR_FWD, DIR_BWD} dir_t;
endpackage

// File: rtl/group_sel_sequencer_btn_debounce.sv
// btn_debounce: synchronises a raw button, debounces its level and pulses on each accepted press
module btn_debounce #(
  parameter int DEB_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);
  localparam int CW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic level;
  logic flip;
  assign flip = sync[1] != level && cnt == CW'(DEB_CYCLES - 1);
  // two-flop synchroniser for the asynchronous button input
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '0;
    else sync <= {sync[0], raw};
  // count consecutive samples differing from the accepted level; flip once the run is long enough
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      level <= 1'b0;
      rise <= 1'b0;
    end else begin
      cnt <= (sync[1] == level || flip) ? '0 : cnt + 1'b1;
      level <= level ^ flip;
      rise <= flip && !level;
    end
endmodule

// File: rtl/group_sel_sequencer.sv
// group_sel_sequencer: steps the mux select over populated slots; optional auto-scan with SEL_SCAN_EN
module group_sel_sequencer
  import group_sel_pkg::*;
#(
  parameter int NSLOT = group_sel_pkg::NSLOT,
  parameter int SEL_W = group_sel_pkg::SEL_W,
  parameter logic [NSLOT-1:0] SLOT_MASK = DEFAULT_SLOT_MASK,
  parameter int DEB_CYCLES = 1000,
  parameter int SCAN_PERIOD = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic btn_next,
  input  logic btn_prev,
  input  logic load,
  input  logic [SEL_W-1:0] load_sel,
  input  logic scan_mode,
  output logic [SEL_W-1:0] sel,
  output logic sel_change,
  output logic busy
);
  state_t state, state_nx;
  dir_t dir, dir_nx;
  logic [SEL_W-1:0] cand, cand_nx;
  logic manual, manual_nx;
  logic next_ev, prev_ev, scan_tick;
  logic idle_act, take, back, hit;
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_next (.clk(clk), .rst_n(rst_n), .raw(btn_next), .rise(next_ev));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_prev (.clk(clk), .rst_n(rst_n), .raw(btn_prev), .rise(prev_ev));
  assign idle_act = state == IDLE && ena;
  assign take = idle_act && (load || next_ev || prev_ev || scan_tick);
  assign back = !load && !next_ev && prev_ev;
  assign hit = state == SEARCH && SLOT_MASK[cand];
`ifdef SEL_SCAN_EN
  localparam int TW = SCAN_PERIOD > 1 ? $clog2(SCAN_PERIOD) : 1;
  logic [TW-1:0] timer;
  logic counting;
  assign counting = scan_mode && idle_act;
  assign scan_tick = counting && timer == TW'(SCAN_PERIOD - 1);
  // scan timer: runs only while idle and enabled, restarts on wrap, scan off or a manual commit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) timer <= '0;
    else if (!scan_mode || scan_tick || (hit && manual)) timer <= '0;
    else if (counting) timer <= timer + 1'b1;
`else
  logic unused_scan;
  assign unused_scan = ^{scan_mode, manual, SCAN_PERIOD[0]};
  assign scan_tick = 1'b0;
`endif
  // FSM state, candidate, direction and event-origin registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      dir <= DIR_FWD;
      cand <= '0;
      manual <= 1'b0;
    end else begin
      state <= state_nx;
      dir <= dir_nx;
      cand <= cand_nx;
      manual <= manual_nx;
    end
  // next state: idle arbitrates load > next > prev > scan; search walks one candidate per cycle
  always_comb begin
    state_nx = state;
    dir_nx = dir;
    cand_nx = cand;
    manual_nx = manual;
    if (state == IDLE) begin
      if (take) begin
        state_nx = SEARCH;
        dir_nx = back ? DIR_BWD : DIR_FWD;
        cand_nx = load ? load_sel : back ? sel - 1'b1 : sel + 1'b1;
        manual_nx = load || next_ev || prev_ev;
      end
    end else if (hit) state_nx = IDLE;
    else cand_nx = dir == DIR_BWD ? cand - 1'b1 : cand + 1'b1;
  end
  // outputs: busy follows the search state
  always_comb busy = state == SEARCH;
  // committed select and its one-cycle change pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sel <= '0;
      sel_change <= 1'b0;
    end else begin
      sel <= hit ? cand : sel;
      sel_change <= hit;
    end
endmodule

// File: tb/tb_group_sel_sequencer.sv
// tb_group_sel_sequencer: randomized self-checking bench with a slot-walk reference model
module tb_group_sel_sequencer;
  localparam logic [15:0] MASK = 16'hFEFF;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic btn_next = 1'b0;
  logic btn_prev = 1'b0;
  logic load = 1'b0;
  logic [3:0] load_sel = '0;
  logic scan_mode = 1'b0;
  logic [3:0] sel;
  logic sel_change;
  logic busy;
  int checks = 0;
  int failures = 0;
  int sel_m = 0;
  always #5 clk = ~clk;
  group_sel_sequencer #(.NSLOT(16), .SEL_W(4), .SLOT_MASK(16'hFEFF), .DEB_CYCLES(4), .SCAN_PERIOD(20)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn_next(btn_next), .btn_prev(btn_prev),
    .load(load), .load_sel(load_sel), .scan_mode(scan_mode),
    .sel(sel), .sel_change(sel_change), .busy(busy)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int next_pop(input int s, input int d, output int skips);
    int c;
    skips = 0;
    c = (s + d + 16) % 16;
    while (!MASK[c]) begin
      c = (c + d + 16) % 16;
      skips++;
    end
    return c;
  endfunction
  task automatic press(input bit fwd, output int pulses, output int busy_cyc);
    pulses = 0;
    busy_cyc = 0;
    if (fwd) btn_next = 1'b1;
    else btn_prev = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 10) begin
        btn_next = 1'b0;
        btn_prev = 1'b0;
      end
      pulses += int'(sel_change);
      busy_cyc += int'(busy);
    end
  endtask
  task automatic step_button(input bit fwd);
    int skips, exp, pulses, busy_cyc;
    exp = next_pop(sel_m, fwd ? 1 : -1, skips);
    press(fwd, pulses, busy_cyc);
    check(fwd ? "next_pulses" : "prev_pulses", pulses, 1);
    check(fwd ? "next_busy" : "prev_busy", busy_cyc, 1 + skips);
    check(fwd ? "next_sel" : "prev_sel", int'(sel), exp);
    sel_m = exp;
  endtask
  task automatic do_load(input int v);
    int skips, exp, lat, pulses;
    exp = next_pop((v + 15) % 16, 1, skips);
    @(negedge clk);
    load = 1'b1;
    load_sel = 4'(v);
    @(negedge clk);
    load = 1'b0;
    lat = 0;
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (sel_change) begin
        pulses++;
        if (lat == 0) lat = k;
      end
    end
    check("load_latency", lat, 1 + skips);
    check("load_pulses", pulses, 1);
    check("load_sel", int'(sel), exp);
    sel_m = exp;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int bad_sel, bad_busy, bad_chg, pulses, busy_cyc, seen, waited;
    repeat (3) @(negedge clk);
    check("reset_sel", int'(sel), 0);
    check("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    bad_sel = 0;
    bad_busy = 0;
    bad_chg = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      bad_sel |= int'(sel);
      bad_busy |= int'(busy);
      bad_chg |= int'(sel_change);
    end
    check("idle_sel", bad_sel, 0);
    check("idle_busy", bad_busy, 0);
    check("idle_change", bad_chg, 0);
    do_load(7);
    step_button(1'b1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      btn_next = (i / 3) % 2 == 0;
      @(negedge clk);
      pulses += int'(sel_change) + int'(busy);
    end
    btn_next = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_activity", pulses, 0);
    check("glitch_sel", int'(sel), sel_m);
    do_load(0);
    step_button(1'b0);
    do_load(8);
    do_load(9);
    load = 1'b1;
    load_sel = 4'd3;
    btn_next = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 10) btn_next = 1'b0;
    end
    load = 1'b0;
    repeat (4) @(negedge clk);
    check("priority_sel", int'(sel), 3);
    sel_m = 3;
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 2))
        0: do_load(int'($urandom_range(0, 15)));
        1: step_button(1'b1);
        default: step_button(1'b0);
      endcase
    end
    ena = 1'b0;
    press(1'b1, pulses, busy_cyc);
    check("ena_off_pulses", pulses, 0);
    check("ena_off_sel", int'(sel), sel_m);
    ena = 1'b1;
    repeat (4) @(negedge clk);
    do_load(7);
    btn_next = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = int'(busy);
    end
    check("midsearch_busy_seen", seen, 1);
    rst_n = 1'b0;
    #1;
    check("abort_sel", int'(sel), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_change", int'(sel_change), 0);
    btn_next = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("after_abort_sel", int'(sel), 0);
    sel_m = 0;
    scan_mode = 1'b1;
`ifdef SEL_SCAN_EN
    for (int s = 0; s < 17; s++) begin
      int skips, exp;
      exp = next_pop(sel_m, 1, skips);
      seen = 0;
      waited = 0;
      while (!seen && waited < 60) begin
        @(negedge clk);
        seen = int'(sel_change);
        waited++;
      end
      check("scan_step_seen", seen, 1);
      check("scan_step_sel", int'(sel), exp);
      sel_m = exp;
    end
`else
    waited = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      waited += int'(sel_change);
    end
    check("noscan_pulses", waited, 0);
    check("noscan_sel", int'(sel), 0);
`endif
    scan_mode = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
